// File: rtl/gpio_cfg_serializer_if.sv
// rtl/gpio_cfg_serializer_if.sv - request/status/bus bundle for the GPIO configuration serializer
interface gpio_cfg_serializer_if #(
    parameter int GPIO_BUS_WIDTH = 16,
    parameter int DATA_WIDTH     = 256,
    parameter int DIV_WIDTH      = 8
);
    localparam int NW = $clog2(DATA_WIDTH) + 1;

    logic                      start;
    logic [7:0]                sel;
    logic [NW-1:0]             nbits;
    logic [DATA_WIDTH-1:0]     data;
    logic [DIV_WIDTH-1:0]      div;
    logic                      abort;
    logic                      ready;
    logic                      done;
    logic                      err;
    logic [GPIO_BUS_WIDTH-1:0] gpio_out;

    modport master (
        output start, sel, nbits, data, div, abort,
        input  ready, done, err, gpio_out
    );

    modport slave (
        input  start, sel, nbits, data, div, abort,
        output ready, done, err, gpio_out
    );
endinterface

// File: rtl/gpio_cfg_serializer.sv
// rtl/gpio_cfg_serializer.sv - MSB-first word serializer driving sdata and a selected strobe on the GPIO bus
module gpio_cfg_serializer #(
    parameter int GPIO_BUS_WIDTH = 16,
    parameter int DATA_WIDTH     = 256,
    parameter int DIV_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    gpio_cfg_serializer_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int NW = CW + 1;
    localparam logic [NW-1:0] MAX_NBITS = NW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        DONE
    } state_t;

    state_t                    state, state_n;
    logic [DATA_WIDTH-1:0]     data_q, data_n;
    logic [7:0]                sel_q, sel_n;
    logic [DIV_WIDTH-1:0]      d_q, d_n;
    logic [DIV_WIDTH-1:0]      phase_q, phase_n;
    logic [CW-1:0]             bit_q, bit_n;
    logic [GPIO_BUS_WIDTH-1:0] gpio_n;
    logic [GPIO_BUS_WIDTH-1:0] strobe_mask;
    logic                      err_n;
    logic                      sel_ok;
    logic                      nbits_ok;
    logic [DIV_WIDTH-1:0]      div_eff;

    // Request qualification: only real shift-register clock lines may be targeted,
    // never sdata, pl_rst or the trigger line.
    always_comb begin
        sel_ok = 1'b0;
        case (bus.sel)
            8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8,
            8'd9, 8'd10, 8'd11, 8'd12: sel_ok = 1'b1;
            default:                  sel_ok = 1'b0;
        endcase
    end

    assign nbits_ok    = (bus.nbits != '0) && (bus.nbits <= MAX_NBITS);
    assign div_eff     = (bus.div == '0) ? DIV_WIDTH'(1) : bus.div;
    assign strobe_mask = GPIO_BUS_WIDTH'(1) << sel_q;

    // Next-state and next-output logic; outputs are computed for the coming state
    // so that the bus registers show the new phase in the first cycle of it.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        sel_n   = sel_q;
        d_n     = d_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        gpio_n  = '0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (sel_ok && nbits_ok) begin
                        state_n   = SETUP;
                        data_n    = bus.data;
                        sel_n     = bus.sel;
                        d_n       = div_eff;
                        phase_n   = div_eff - 1'b1;
                        bit_n     = CW'(bus.nbits - NW'(1));
                        gpio_n[0] = bus.data[bit_n];
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SETUP: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (phase_q == '0) begin
                    state_n   = HIGH;
                    phase_n   = d_q - 1'b1;
                    gpio_n[0] = data_q[bit_q];
                    gpio_n    = gpio_n | strobe_mask;
                end else begin
                    phase_n   = phase_q - 1'b1;
                    gpio_n[0] = data_q[bit_q];
                end
            end

            HIGH: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (phase_q == '0) begin
                    if (bit_q == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n   = SETUP;
                        bit_n     = bit_q - 1'b1;
                        phase_n   = d_q - 1'b1;
                        gpio_n[0] = data_q[bit_n];
                    end
                end else begin
                    phase_n   = phase_q - 1'b1;
                    gpio_n[0] = data_q[bit_q];
                    gpio_n    = gpio_n | strobe_mask;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Latched request and bit/phase counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            sel_q   <= '0;
            d_q     <= '0;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            data_q  <= data_n;
            sel_q   <= sel_n;
            d_q     <= d_n;
            phase_q <= phase_n;
            bit_q   <= bit_n;
        end
    end

    // Registered status and bus outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.gpio_out <= '0;
        end else begin
            bus.ready    <= (state_n == IDLE);
            bus.done     <= (state_n == DONE);
            bus.err      <= err_n;
            bus.gpio_out <= gpio_n;
        end
    end
endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// tb/tb_gpio_cfg_serializer.sv - randomized self-checking bench for gpio_cfg_serializer
module tb_gpio_cfg_serializer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpio_cfg_serializer_if bus ();

    gpio_cfg_serializer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected bus value in busy cycle c: bit k occupies 2d cycles, strobe high in its second half.
    function automatic logic [15:0] model_gpio(input logic [7:0] s, input int n,
                                               input logic [255:0] dat, input int d, input int c);
        logic [15:0] g;
        int k;
        int ph;
        k  = c / (2 * d);
        ph = c % (2 * d);
        g  = '0;
        g[0] = dat[n - 1 - k];
        if (ph >= d) g[s[3:0]] = 1'b1;
        return g;
    endfunction

    // Issues a request in the current cycle and checks the whole transfer against the model.
    task automatic run_transfer(input logic [7:0] s, input int n, input logic [255:0] dat,
                                input int dv, input string name);
        int d;
        int total;
        int first_bad;
        int pulses;
        logic [15:0] exp_g;
        logic [15:0] bad_got;
        logic [15:0] bad_exp;
        logic [2:0]  bad_st;
        logic [255:0] recon;
        logic [255:0] mask;
        logic prev;
        d         = (dv == 0) ? 1 : dv;
        total     = 2 * n * d;
        first_bad = -1;
        pulses    = 0;
        recon     = '0;
        prev      = 1'b0;
        bad_got   = '0;
        bad_exp   = '0;
        bad_st    = '0;

        bus.sel   = s;
        bus.nbits = 9'(n);
        bus.data  = dat;
        bus.div   = 8'(dv);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.data  = rand256();
        bus.nbits = 9'($urandom_range(1, 256));
        bus.div   = 8'($urandom_range(0, 255));

        for (int c = 0; c < total; c++) begin
            exp_g = model_gpio(s, n, dat, d, c);
            if ((bus.gpio_out !== exp_g || bus.ready !== 1'b0 || bus.done !== 1'b0 ||
                 bus.err !== 1'b0) && first_bad < 0) begin
                first_bad = c;
                bad_got   = bus.gpio_out;
                bad_exp   = exp_g;
                bad_st    = {bus.ready, bus.done, bus.err};
            end
            if (bus.gpio_out[s[3:0]] === 1'b1 && !prev) begin
                recon  = {recon[254:0], bus.gpio_out[0]};
                pulses = pulses + 1;
            end
            prev = bus.gpio_out[s[3:0]];
            step();
        end

        checks++;
        if (first_bad >= 0) begin
            errors++;
            $display("FAIL %s waveform: cycle %0d got gpio=%h ready/done/err=%b, required gpio=%h ready/done/err=000",
                     name, first_bad, bad_got, bad_st, bad_exp);
        end

        checks++;
        if (bus.done !== 1'b1 || bus.gpio_out !== 16'h0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: cycle %0d got done=%b gpio=%h ready=%b, required done=1 gpio=0000 ready=0",
                     name, total, bus.done, bus.gpio_out, bus.ready);
        end
        step();

        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_return: got ready=%b done=%b, required ready=1 done=0",
                     name, bus.ready, bus.done);
        end

        mask = (n >= 256) ? {256{1'b1}} : ((256'd1 << n) - 256'd1);
        checks++;
        if (recon !== (dat & mask)) begin
            errors++;
            $display("FAIL %s reconstruct: got %h required %h", name, recon, dat & mask);
        end

        checks++;
        if (pulses != n) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d required %0d", name, pulses, n);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sel   = '0;
        bus.nbits = '0;
        bus.data  = '0;
        bus.div   = '0;
        rstn      = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.gpio_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b done=%b err=%b gpio=%h, required 1 0 0 0000",
                     bus.ready, bus.done, bus.err, bus.gpio_out);
        end
    endtask

    task automatic test_div1_sel2();
        run_transfer(8'd2, 16, 256'h0004, 1, "div1_sel2");
    endtask

    task automatic test_long_word();
        logic [255:0] aa;
        aa = {32{8'hAA}};
        run_transfer(8'd3, 256, aa, 3, "long_256");
    endtask

    task automatic test_reject();
        logic [7:0] rs [6] = '{8'd6, 8'd0, 8'd2, 8'd2, 8'd5, 8'd13};
        int         rn [6] = '{8, 8, 0, 257, 8, 8};
        for (int i = 0; i < 6; i++) begin
            bus.sel   = rs[i];
            bus.nbits = 9'(rn[i]);
            bus.data  = rand256();
            bus.div   = 8'($urandom_range(0, 4));
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            checks++;
            if (bus.err !== 1'b1 || bus.gpio_out !== 16'h0 || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL reject_%0d err_pulse: got err=%b gpio=%h ready=%b, required 1 0000 1",
                         i, bus.err, bus.gpio_out, bus.ready);
            end
            step();
            checks++;
            if (bus.err !== 1'b0 || bus.gpio_out !== 16'h0 || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL reject_%0d after: got err=%b gpio=%h ready=%b, required 0 0000 1",
                         i, bus.err, bus.gpio_out, bus.ready);
            end
        end
    endtask

    task automatic test_div0();
        run_transfer(8'd12, 1, 256'h1, 0, "div0");
    endtask

    task automatic test_abort();
        int d;
        d = $urandom_range(1, 3);
        bus.sel   = 8'd9;
        bus.nbits = 9'd10;
        bus.data  = rand256();
        bus.div   = 8'(d);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 11 * d; c++) step();
        checks++;
        if (bus.gpio_out[9] !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_high: got strobe=%b required 1", bus.gpio_out[9]);
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.sel   = 8'd2;
        bus.nbits = 9'd4;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.gpio_out !== 16'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: got gpio=%h ready=%b done=%b err=%b, required 0000 1 0 0",
                     bus.gpio_out, bus.ready, bus.done, bus.err);
        end
        run_transfer(8'd4, 6, rand256(), 2, "after_abort");
    endtask

    task automatic test_reset_mid();
        bus.sel   = 8'd4;
        bus.nbits = 9'd8;
        bus.data  = rand256();
        bus.div   = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 13; c++) step();
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.gpio_out !== 16'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got gpio=%h ready=%b done=%b, required 0000 1 0",
                     bus.gpio_out, bus.ready, bus.done);
        end
        step();
        rstn = 1'b1;
        run_transfer(8'd7, 12, rand256(), 1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] legal [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        for (int i = 0; i < 10; i++) begin
            run_transfer(legal[$urandom_range(0, 9)], $urandom_range(1, 24), rand256(),
                         $urandom_range(0, 4), $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_div1_sel2();
        test_long_word();
        test_reject();
        test_div0();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_cfg_serializer.md
# gpio_cfg_serializer

Drives the shared GPIO configuration bus. It serializes a configuration word MSB-first onto `sdata` (bit 0) and toggles the selected register's serial clock line, as the PL-side shift registers expect. Typical targets are the mask, select, cycle-count, mux, ADC-average and delay registers. It sits in the fabric as a bus master for self-test and autonomous sequencing, driving the same 16-bit bus the PS GPIO drives.

## Interface
- `GPIO_BUS_WIDTH`, 16: width of `gpio_out`.
- `DATA_WIDTH`, 256: maximum word length; matches the config register width.
- `DIV_WIDTH`, 8: width of the half-period divider.
- `clk`  in  1: fabric clock; all state is updated on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; accepted when `start && ready`.
- `sel`  in  8: GPIO line index of the target serial clock.
- `nbits`  in  9: number of bits to shift, 1..`DATA_WIDTH`.
- `data`  in  `DATA_WIDTH`: word to shift; bits [nbits-1:0] are used.
- `div`  in  `DIV_WIDTH`: half-period in clk cycles; 0 is treated as 1.
- `abort`  in  1: synchronous cancel of the transfer in progress.
- `ready`  out  1: idle and able to accept `start`.
- `done`  out  1: one-cycle pulse on successful completion.
- `err`  out  1: one-cycle pulse when a request is rejected.
- `gpio_out`  out  `GPIO_BUS_WIDTH`: registered bus outputs; bit 0 = `sdata`.

## Operation
- States: IDLE, SETUP, HIGH, DONE. All outputs are registered.
- Legal `sel` values: 1, 2, 3, 4, 7, 8, 9, 10, 11, 12.
  - `sel` of 0 (sdata), 5 (pl_rst), 6 (trigger_line), 13..255, or `nbits` of 0 or >`DATA_WIDTH` rejects the request.
  - On rejection: `err`=1 for one cycle, state stays IDLE, `ready` stays 1, `gpio_out` is unchanged (0).
- On acceptance, the block latches `data`, `nbits`, `sel` and effective `d`=max(`div`,1), and enters SETUP.
  - Bit counter = `nbits`-1; the transfer is MSB-first, from bit `nbits`-1 down to bit 0.
- SETUP: `gpio_out[0]` = current bit, `gpio_out[sel]`=0, hold for `d` cycles, then go to HIGH.
- HIGH: `gpio_out[0]` holds the current bit, `gpio_out[sel]`=1, hold for `d` cycles.
  - If the bit counter is 0, go to DONE.
  - Otherwise decrement the counter and return to SETUP.
- DONE: `gpio_out`=0 and `done`=1 for one cycle, then IDLE.
- `abort` in SETUP or HIGH: next cycle the state is IDLE and `gpio_out`=0, with no `done` and no `err`. `abort` in IDLE or DONE is ignored.
- `start` while busy is ignored, with no error.
- Only `gpio_out[0]` and `gpio_out[sel]` are ever non-zero; every other bit is constant 0.
- Bits of `data` above `nbits`-1 are ignored.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `gpio_out`=0. Reset mid-transfer drops everything immediately (asynchronous).
- `start` is accepted at edge T, giving busy cycle 0 = T+1.
- For bit k (k=0 is the MSB sent):
  - `sdata` is valid in cycles [2kd, 2(k+1)d).
  - The strobe is high in cycles [(2k+1)d, 2(k+1)d).
  - `sdata` is therefore stable `d` cycles before the rising edge and throughout the high phase.
- Strobe falls and `sdata` changes on the same edge. The receiver samples on the rising edge, so this is safe.
- DONE occupies cycle 2·nbits·d with `done`=1. `ready` returns to 1 in the following cycle, and a new `start` is accepted there.
- `ready`=0 from T+1 through the DONE cycle.
- `err` is asserted in cycle T+1.

## Test plan
- Reset with `rstn`=0 mid-transfer at bit 3 → `gpio_out`=0 and `ready`=1 immediately; after release, the next `start` runs cleanly.
- `sel`=2, `nbits`=16, `data`=0x0004, `div`=1 → 16 strobe pulses on `gpio_out[2]`, each high 1 cycle. `sdata`=1 only for the 14th bit sent (bit 2). `done` is in cycle 32.
- `sel`=3, `nbits`=256, `data`=alternating 0xAA.., `div`=3 → 256 pulses, each 3 cycles low + 3 high. A bench shift register reconstructs `data` exactly. `done` is at cycle 1536.
- `sel`=6, then `sel`=0, then `nbits`=0, then `nbits`=257 → `err` pulses in cycle T+1 each time, with `gpio_out` staying 0 and `ready` staying 1.
- `div`=0, `nbits`=1, `sel`=12, `data`=1 → behaves as `div`=1: `sdata`=1 in cycles 0–1, strobe high in cycle 1, `done` in cycle 2.
- `abort` during HIGH of bit 5 with `sel`=9 → next cycle `gpio_out`=0 and no `done`. A `start` issued on the same cycle as the abort is ignored, and a `start` the cycle after is accepted.
